lat_dual_port_mem: RTL

Parametrised, cycle-accurate dual-port memory responder used as the CPU's backing store in simulation and emulation builds. It is the successor to the zero-latency dual-port memory: it adds a valid/ready request handshake, configurable per-port response latency, bounded outstanding requests and misalignment reporting. Port I is a read-only instruction port and port D is a read/write data port with byte masks. Both ports share one word array.

---
 rtl/lat_dual_port_mem.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lat_dual_port_mem.sv
// lat_dual_port_mem: shared-array dual-port memory responder.
// Port I is read-only. Port D reads and writes with byte masks.
// Each port has a fixed-latency response pipeline and an outstanding-request
// limit. Misaligned accepted requests set a sticky flag.
// Optional feature macro: LAT_MEM_STALL_EN. When it is defined, a 16-bit LFSR
// injects pseudo-random back-pressure on both ready outputs.
module lat_dual_port_mem #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int I_LAT   = 1,
   parameter int D_LAT   = 2,
   parameter int MAX_OUT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_ready,
   output logic                  i_resp,
   output logic [DATA_W-1:0]     i_rdata,
   input  logic                  d_req,
   input  logic                  d_write,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W/8-1:0]   d_wmask,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_ready,
   output logic                  d_resp,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  misalign
);

   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(MAX_OUT + 1);
   localparam int MASK_W = DATA_W / 8;

   if (I_LAT < 1)   begin : g_bad_i_lat   $error("I_LAT must be at least 1");   end
   if (D_LAT < 1)   begin : g_bad_d_lat   $error("D_LAT must be at least 1");   end
   if (MAX_OUT < 1) begin : g_bad_max_out $error("MAX_OUT must be at least 1"); end
   if (DATA_W != 32) begin : g_bad_data_w $error("DATA_W must be 32");          end

   // Word index: byte address without its low two bits, wrapped to the array depth.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] w;
      w = addr >> 2;
      return IDX_W'(w % ADDR_W'(DEPTH));
   endfunction

   // Replace only the bytes whose enable bit is set.
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [MASK_W-1:0] mask);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int b = 0; b < MASK_W; b++) begin
         if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [CNT_W-1:0]  i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
   logic [I_LAT-1:0]  i_vld_q, i_vld_d;
   logic [D_LAT-1:0]  d_vld_q, d_vld_d;
   logic [DATA_W-1:0] i_dat_q [I_LAT];
   logic [DATA_W-1:0] i_dat_d [I_LAT];
   logic [DATA_W-1:0] d_dat_q [D_LAT];
   logic [DATA_W-1:0] d_dat_d [D_LAT];
   logic              misalign_q, misalign_d;

   logic              i_retire, d_retire, i_acc, d_acc;
   logic [IDX_W-1:0]  i_idx, d_idx;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              i_stall, d_stall;

`ifdef LAT_MEM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR next state (taps 16,14,13,11).
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR register, advancing on every non-reset cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end

   assign i_stall = lfsr_q[0];
   assign d_stall = lfsr_q[1];
`else
   assign i_stall = 1'b0;
   assign d_stall = 1'b0;
`endif

   assign i_retire = i_vld_q[I_LAT-1];
   assign d_retire = d_vld_q[D_LAT-1];
   assign i_resp   = i_vld_q[I_LAT-1];
   assign i_rdata  = i_dat_q[I_LAT-1];
   assign d_resp   = d_vld_q[D_LAT-1];
   assign d_rdata  = d_dat_q[D_LAT-1];
   assign misalign = misalign_q;

   // Handshake: a slot frees up in the same cycle a response retires.
   always_comb begin
      i_ready   = rst_n & ~i_stall & ((i_cnt_q < CNT_W'(MAX_OUT)) | i_retire);
      d_ready   = rst_n & ~d_stall & ((d_cnt_q < CNT_W'(MAX_OUT)) | d_retire);
      i_acc     = i_req & i_ready;
      d_acc     = d_req & d_ready;
      i_idx     = word_idx(i_addr);
      d_idx     = word_idx(d_addr);
      mem_we    = d_acc & d_write;
      mem_wdata = merge_bytes(mem_q[d_idx], d_wdata, d_wmask);
   end

   // Next state of the outstanding counters, response pipelines and misalign flag.
   always_comb begin
      i_cnt_d = i_cnt_q;
      if (i_acc && !i_retire)      i_cnt_d = i_cnt_q + 1'b1;
      else if (!i_acc && i_retire) i_cnt_d = i_cnt_q - 1'b1;

      d_cnt_d = d_cnt_q;
      if (d_acc && !d_retire)      d_cnt_d = d_cnt_q + 1'b1;
      else if (!d_acc && d_retire) d_cnt_d = d_cnt_q - 1'b1;

      // Read data is captured before this edge's write, so a same-edge
      // D write is invisible to a same-edge I read.
      i_vld_d    = i_vld_q << 1;
      i_vld_d[0] = i_acc;
      i_dat_d[0] = i_acc ? mem_q[i_idx] : '0;
      for (int s = 1; s < I_LAT; s++) i_dat_d[s] = i_dat_q[s-1];

      d_vld_d    = d_vld_q << 1;
      d_vld_d[0] = d_acc;
      d_dat_d[0] = (d_acc && !d_write) ? mem_q[d_idx] : '0;
      for (int s = 1; s < D_LAT; s++) d_dat_d[s] = d_dat_q[s-1];

      misalign_d = misalign_q
                 | (i_acc & (i_addr[1:0] != 2'b00))
                 | (d_acc & (d_addr[1:0] != 2'b00));
   end

   // Control and response registers; reset flushes everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         i_cnt_q    <= '0;
         d_cnt_q    <= '0;
         i_vld_q    <= '0;
         d_vld_q    <= '0;
         misalign_q <= 1'b0;
         for (int s = 0; s < I_LAT; s++) i_dat_q[s] <= '0;
         for (int s = 0; s < D_LAT; s++) d_dat_q[s] <= '0;
      end else begin
         i_cnt_q    <= i_cnt_d;
         d_cnt_q    <= d_cnt_d;
         i_vld_q    <= i_vld_d;
         d_vld_q    <= d_vld_d;
         misalign_q <= misalign_d;
         for (int s = 0; s < I_LAT; s++) i_dat_q[s] <= i_dat_d[s];
         for (int s = 0; s < D_LAT; s++) d_dat_q[s] <= d_dat_d[s];
      end
   end

   // Word array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[d_idx] <= mem_wdata;
   end

endmodule
